// File: rtl/rgb_batch_sequencer.sv
// Batch job controller for the 16-entry RGB mask memory unit: runs fill or
// operation-sweep jobs over a wrapping address range and streams sweep results.
module rgb_batch_sequencer #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic              job_mode,
  input  logic [2:0]        job_op,
  input  logic [ADDR_W-1:0] job_base,
  input  logic [ADDR_W-1:0] job_len,
  input  logic [23:0]       job_rgb,
  output logic              mem_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_rgb,
  output logic [2:0]        mem_op,
  input  logic [23:0]       mem_rgb_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [23:0]       res_data,
  output logic [ADDR_W-1:0] res_addr,
  output logic              busy,
  output logic              done,
  output logic [23:0]       checksum
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t            state_reg, state_next;
  logic [2:0]        op_reg;
  logic [23:0]       rgb_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] left_reg;
  logic [CNT_W-1:0]  wait_cnt_reg;
  logic [23:0]       res_data_reg;
  logic [ADDR_W-1:0] res_addr_reg;
  logic [23:0]       checksum_reg;
  logic              wait_last;

  assign wait_last = (wait_cnt_reg == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (job_valid) state_next = job_mode ? S_ISSUE : S_FILL;
      S_FILL:  if (left_reg == '0) state_next = S_FIN;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (wait_last) state_next = S_HOLD;
      S_HOLD:  if (res_ready) state_next = (left_reg == '0) ? S_FIN : S_ISSUE;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Every state other than FILL/ISSUE presents the harmless idle command.
  always_comb begin
    mem_mode  = 1'b1;
    mem_op    = 3'b000;
    mem_addr  = '0;
    mem_rgb   = '0;
    job_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    res_valid = 1'b0;
    case (state_reg)
      S_IDLE: begin
        job_ready = 1'b1;
        busy      = 1'b0;
      end
      S_FILL: begin
        mem_mode = 1'b0;
        mem_addr = addr_reg;
        mem_rgb  = rgb_reg;
      end
      S_ISSUE: begin
        mem_op   = op_reg;
        mem_addr = addr_reg;
        mem_rgb  = rgb_reg;
      end
      S_HOLD: res_valid = 1'b1;
      S_FIN: begin
        done = 1'b1;
        busy = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_reg       <= '0;
      rgb_reg      <= '0;
      addr_reg     <= '0;
      left_reg     <= '0;
      wait_cnt_reg <= '0;
      res_data_reg <= '0;
      res_addr_reg <= '0;
      checksum_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (job_valid) begin
            op_reg   <= job_op;
            rgb_reg  <= job_rgb;
            addr_reg <= job_base;
            left_reg <= job_len;
            // Fill jobs leave the previous sweep's checksum visible.
            if (job_mode) checksum_reg <= '0;
          end
        end
        S_FILL: begin
          addr_reg <= addr_reg + ADDR_W'(1);
          left_reg <= left_reg - ADDR_W'(1);
        end
        S_ISSUE: wait_cnt_reg <= '0;
        S_WAIT: begin
          if (wait_last) begin
            res_data_reg <= mem_rgb_out;
            res_addr_reg <= addr_reg;
            checksum_reg <= checksum_reg ^ mem_rgb_out;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (res_ready && (left_reg != '0)) begin
            left_reg <= left_reg - ADDR_W'(1);
            addr_reg <= addr_reg + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign res_data = res_data_reg;
  assign res_addr = res_addr_reg;
  assign checksum = checksum_reg;

endmodule

// File: tb/tb_rgb_batch_sequencer.sv
// Bench for rgb_batch_sequencer: two instances (MEM_LAT 1 and 2) with stub mask
// units, run in lockstep and compared each cycle against a job-level model.
module tb_rgb_batch_sequencer;

  localparam int AW = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST;
  logic          job_valid;
  logic          job_mode;
  logic [2:0]    job_op;
  logic [AW-1:0] job_base;
  logic [AW-1:0] job_len;
  logic [23:0]   job_rgb;
  logic          res_ready;

  logic          job_ready_w [2];
  logic          mem_mode_w  [2];
  logic [AW-1:0] mem_addr_w  [2];
  logic [23:0]   mem_rgb_w   [2];
  logic [2:0]    mem_op_w    [2];
  logic          res_valid_w [2];
  logic [23:0]   res_data_w  [2];
  logic [AW-1:0] res_addr_w  [2];
  logic          busy_w      [2];
  logic          done_w      [2];
  logic [23:0]   checksum_w  [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int LAT = gi + 1;
      logic [23:0] rout;
      logic [23:0] smem [16];
      logic [23:0] pipe [LAT];

      rgb_batch_sequencer #(.MEM_LAT(LAT), .ADDR_W(AW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .job_valid  (job_valid),
        .job_ready  (job_ready_w[gi]),
        .job_mode   (job_mode),
        .job_op     (job_op),
        .job_base   (job_base),
        .job_len    (job_len),
        .job_rgb    (job_rgb),
        .mem_mode   (mem_mode_w[gi]),
        .mem_addr   (mem_addr_w[gi]),
        .mem_rgb    (mem_rgb_w[gi]),
        .mem_op     (mem_op_w[gi]),
        .mem_rgb_out(rout),
        .res_valid  (res_valid_w[gi]),
        .res_ready  (res_ready),
        .res_data   (res_data_w[gi]),
        .res_addr   (res_addr_w[gi]),
        .busy       (busy_w[gi]),
        .done       (done_w[gi]),
        .checksum   (checksum_w[gi])
      );

      // Stub mask unit: reads return stored value after LAT edges, Mode=0 writes.
      initial for (int a = 0; a < 16; a++) smem[a] = 24'hA00000 | 24'(a);
      always @(posedge CLK) begin
        pipe[0] <= smem[mem_addr_w[gi]];
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        if (!mem_mode_w[gi]) smem[mem_addr_w[gi]] <= mem_rgb_w[gi];
      end
      assign rout = pipe[LAT-1];
    end
  endgenerate

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          checking = 1'b0;
  int          rr_mode = 0;

  int          m_phase    [2];
  int          m_issue_at [2];
  int          m_valid_at [2];
  int          m_done_at  [2];
  int          m_start    [2];
  int          m_left     [2];
  logic [3:0]  m_addr     [2];
  logic [3:0]  m_base     [2];
  logic [2:0]  m_op       [2];
  logic [23:0] m_rgb      [2];
  logic [23:0] m_chk      [2];
  logic [23:0] m_last_data[2];
  logic [3:0]  m_last_addr[2];
  logic [23:0] m_mem      [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset(input int i);
    m_phase[i]     = 0;
    m_issue_at[i]  = -1;
    m_valid_at[i]  = -1;
    m_done_at[i]   = -1;
    m_chk[i]       = '0;
    m_last_data[i] = '0;
    m_last_addr[i] = '0;
  endtask

  // Phases: 0 idle, 1 fill, 2 sweep. Timing follows directly from the job rules:
  // fill done at accept+len+2; a sweep issue at t yields a result at t+LAT+1.
  task automatic cycle_check(input int i);
    int c;
    int lat;
    logic [31:0] e_cmd;
    logic [31:0] g_cmd;
    logic [3:0]  e_stat;
    logic [3:0]  g_stat;
    logic [3:0]  fa;
    logic        hs;
    c = cyc;
    lat = i + 1;
    e_cmd = {1'b1, 3'b000, 4'h0, 24'h0};
    e_stat = 4'b0100;
    hs = 1'b0;
    fa = '0;
    case (m_phase[i])
      0: e_stat = 4'b1000;
      1: begin
        if (c < m_done_at[i]) begin
          fa = m_base[i] + 4'(c - m_start[i]);
          e_cmd = {1'b0, 3'b000, fa, m_rgb[i]};
          m_mem[fa] = m_rgb[i];
        end else begin
          e_stat = 4'b0010;
        end
      end
      default: begin
        if (c == m_issue_at[i]) begin
          e_cmd = {1'b1, m_op[i], m_addr[i], m_rgb[i]};
        end else if (m_valid_at[i] >= 0 && c >= m_valid_at[i]) begin
          if (c == m_valid_at[i]) begin
            m_last_data[i] = m_mem[m_addr[i]];
            m_last_addr[i] = m_addr[i];
            m_chk[i] = m_chk[i] ^ m_last_data[i];
          end
          e_stat = 4'b0101;
          hs = res_ready;
        end else if (c == m_done_at[i]) begin
          e_stat = 4'b0010;
        end
      end
    endcase

    g_cmd  = {mem_mode_w[i], mem_op_w[i], mem_addr_w[i], mem_rgb_w[i]};
    g_stat = {job_ready_w[i], busy_w[i], done_w[i], res_valid_w[i]};
    check($sformatf("cmd%0d", i), 64'(g_cmd), 64'(e_cmd));
    check($sformatf("status%0d", i), 64'(g_stat), 64'(e_stat));
    check($sformatf("result%0d", i), 64'({res_addr_w[i], res_data_w[i]}),
          64'({m_last_addr[i], m_last_data[i]}));
    check($sformatf("checksum%0d", i), 64'(checksum_w[i]), 64'(m_chk[i]));

    case (m_phase[i])
      0: begin
        if (job_valid) begin
          m_op[i]   = job_op;
          m_rgb[i]  = job_rgb;
          m_base[i] = job_base;
          m_addr[i] = job_base;
          m_left[i] = int'(job_len) + 1;
          m_start[i] = c + 1;
          if (!job_mode) begin
            m_phase[i]   = 1;
            m_done_at[i] = c + int'(job_len) + 2;
          end else begin
            m_phase[i]    = 2;
            m_issue_at[i] = c + 1;
            m_valid_at[i] = -1;
            m_done_at[i]  = -1;
            m_chk[i]      = '0;
          end
        end
      end
      1: begin
        if (c == m_done_at[i]) begin
          m_phase[i] = 0;
          $display("inst%0d fill done base=%0d cycle=%0d", i, m_base[i], c);
        end
      end
      default: begin
        if (hs) begin
          $display("inst%0d result addr=%0d data=%06h", i, m_last_addr[i], m_last_data[i]);
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_done_at[i] = c + 1;
          end else begin
            m_issue_at[i] = c + 1;
            m_addr[i] = m_addr[i] + 4'd1;
          end
          m_valid_at[i] = -1;
        end else if (c == m_issue_at[i]) begin
          m_valid_at[i] = c + lat + 1;
        end else if (c == m_done_at[i]) begin
          m_phase[i] = 0;
          $display("inst%0d sweep done checksum=%06h cycle=%0d", i, m_chk[i], c);
        end
      end
    endcase

    if (RST) model_reset(i);
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) cycle_check(i);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rr_mode == 2) res_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 4000; k++) begin
      if (m_phase[0] == 0 && m_phase[1] == 0) break;
      tick();
    end
    check("idle_timeout", 64'(m_phase[0] + m_phase[1]), 64'd0);
  endtask

  task automatic start_job(input logic mode, input logic [2:0] op, input logic [3:0] base,
                           input logic [3:0] len, input logic [23:0] rgb);
    wait_idle();
    job_mode  = mode;
    job_op    = op;
    job_base  = base;
    job_len   = len;
    job_rgb   = rgb;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic run_job(input logic mode, input logic [2:0] op, input logic [3:0] base,
                         input logic [3:0] len, input logic [23:0] rgb);
    start_job(mode, op, base, len, rgb);
    wait_idle();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) model_reset(i);
    for (int a = 0; a < 16; a++) m_mem[a] = 24'hA00000 | 24'(a);
    RST = 1'b1;
    job_valid = 1'b0;
    job_mode = 1'b0;
    job_op = '0;
    job_base = '0;
    job_len = '0;
    job_rgb = '0;
    res_ready = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    checking = 1'b1;
    tick();

    // Two-entry sweep over the untouched stub contents.
    run_job(1'b1, 3'b001, 4'd2, 4'd1, 24'h0F0F0F);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("sweep_xor%0d", i), 64'(checksum_w[i]), 64'h000001);
      check($sformatf("sweep_last%0d", i), 64'({res_addr_w[i], res_data_w[i]}),
            64'({4'd3, 24'hA00003}));
    end

    // Full-length sweep.
    run_job(1'b1, 3'b101, 4'd0, 4'd15, 24'h00FF00);

    // Wrapping fill, then read three of the written entries back.
    run_job(1'b0, 3'b000, 4'd14, 4'd3, 24'h123456);
    run_job(1'b1, 3'b001, 4'd15, 4'd2, 24'h000000);
    for (int i = 0; i < 2; i++)
      check($sformatf("fill_readback%0d", i), 64'(checksum_w[i]), 64'h123456);

    // Backpressure on a single-entry sweep.
    res_ready = 1'b0;
    start_job(1'b1, 3'b010, 4'd9, 4'd0, 24'h777777);
    repeat (10) tick();
    res_ready = 1'b1;
    wait_idle();

    // A second request while busy must be ignored.
    start_job(1'b1, 3'b011, 4'd6, 4'd4, 24'h0A0B0C);
    repeat (2) tick();
    job_mode = 1'b0;
    job_base = 4'd0;
    job_len = 4'd15;
    job_rgb = 24'hDEAD00;
    job_valid = 1'b1;
    repeat (3) tick();
    job_valid = 1'b0;
    wait_idle();

    // Reset in the middle of a 16-entry fill, then a normal job.
    start_job(1'b0, 3'b000, 4'd5, 4'd15, 24'h5A5A5A);
    repeat (5) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    run_job(1'b1, 3'b111, 4'd3, 4'd7, 24'h010203);

    // Random jobs with random backpressure.
    rr_mode = 2;
    for (int n = 0; n < 30; n++) begin
      run_job(1'($urandom_range(0, 1)), 3'($urandom_range(1, 7)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 24'($urandom));
    end
    rr_mode = 0;
    res_ready = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
